// File: rtl/fdas_ifft_pkg.sv
// Shared constants for the FDAS IFFT back-end: frame geometry defaults,
// sample layout and the overlap-save discard FSM state type.
package fdas_ifft_pkg;

  localparam int unsigned FFT_LEN_DEF = 1024;
  localparam int unsigned OVERLAP_DEF = 420;
  localparam int unsigned SAMPLE_W    = 64;
  localparam int unsigned CHAN_W      = 8;

  localparam int unsigned RE_MSB = 63;
  localparam int unsigned RE_LSB = 32;
  localparam int unsigned IM_MSB = 31;
  localparam int unsigned IM_LSB = 0;

  typedef struct packed {
    logic [RE_MSB-RE_LSB:0] re;
    logic [IM_MSB-IM_LSB:0] im;
  } sample_t;

  typedef enum logic {
    ST_DISCARD = 1'b0,
    ST_PASS    = 1'b1
  } ovlp_state_e;

endpackage

// File: rtl/ifft_ovlp_discard.sv
// Overlap-save discard stage: drops the leading OVERLAP samples of each IFFT
// frame and forwards the rest with bin/sop/eop/frame tags, one cycle latency.
module ifft_ovlp_discard
  import fdas_ifft_pkg::*;
#(
  parameter int unsigned FFT_LEN = FFT_LEN_DEF,
  parameter int unsigned OVERLAP = OVERLAP_DEF,
  parameter int unsigned FRAME_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       validIn,
  input  logic [CHAN_W-1:0]          channelIn,
  input  logic [SAMPLE_W-1:0]        d,
  output logic                       validOut,
  output logic [CHAN_W-1:0]          channelOut,
  output logic [SAMPLE_W-1:0]        q,
  output logic [$clog2(FFT_LEN)-1:0] binOut,
  output logic                       sopOut,
  output logic                       eopOut,
  output logic [FRAME_W-1:0]         frameOut,
  output logic                       errOut
);

  localparam int unsigned IDX_W = $clog2(FFT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0] OVL_IDX  = IDX_W'(OVERLAP);
  // Equals LAST_IDX when OVERLAP is 0, where the frame-end branch wins anyway.
  localparam logic [IDX_W-1:0] OVL_M1   = IDX_W'(OVERLAP + FFT_LEN - 1);
  localparam bit               OVL_ZERO = (OVERLAP == 0);

  ovlp_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [FRAME_W-1:0]  frm_q, frm_d;
  logic                err_q, err_d;
  logic                vout_q, vout_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [CHAN_W-1:0]   chout_q, chout_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]    bin_q, bin_d;
  logic [FRAME_W-1:0]  fout_q, fout_d;

  logic                restart_c;
  logic                pass_c;
  logic [IDX_W-1:0]    idx_eff_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DISCARD;
      idx_q   <= '0;
      chan_q  <= '0;
      frm_q   <= '0;
      err_q   <= 1'b0;
      vout_q  <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      chout_q <= '0;
      data_q  <= '0;
      bin_q   <= '0;
      fout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      frm_q   <= frm_d;
      err_q   <= err_d;
      vout_q  <= vout_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      chout_q <= chout_d;
      data_q  <= data_d;
      bin_q   <= bin_d;
      fout_q  <= fout_d;
    end
  end

  // A channel change mid-frame restarts the frame with this sample as idx 0.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chan_d    = chan_q;
    frm_d     = frm_q;
    err_d     = err_q;
    vout_d    = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    chout_d   = chout_q;
    data_d    = data_q;
    bin_d     = bin_q;
    fout_d    = fout_q;

    restart_c = validIn && (idx_q != '0) && (channelIn != chan_q);
    idx_eff_c = restart_c ? '0 : idx_q;
    pass_c    = OVL_ZERO || (!restart_c && (state_q == ST_PASS));

    if (validIn) begin
      if (idx_eff_c == '0) chan_d = channelIn;
      if (restart_c) err_d = 1'b1;

      if (pass_c) begin
        vout_d  = 1'b1;
        data_d  = d;
        chout_d = channelIn;
        bin_d   = idx_eff_c - OVL_IDX;
        sop_d   = (idx_eff_c == OVL_IDX);
        eop_d   = (idx_eff_c == LAST_IDX);
        fout_d  = frm_q;
      end

      if (idx_eff_c == LAST_IDX) begin
        idx_d   = '0;
        frm_d   = frm_q + FRAME_W'(1);
        state_d = OVL_ZERO ? ST_PASS : ST_DISCARD;
      end else begin
        idx_d = idx_eff_c + IDX_W'(1);
        if (idx_eff_c == OVL_M1) begin
          state_d = ST_PASS;
        end else if (restart_c) begin
          state_d = OVL_ZERO ? ST_PASS : ST_DISCARD;
        end
      end
    end
  end

  assign validOut   = vout_q;
  assign channelOut = chout_q;
  assign q          = data_q;
  assign binOut     = bin_q;
  assign sopOut     = sop_q;
  assign eopOut     = eop_q;
  assign frameOut   = fout_q;
  assign errOut     = err_q;

endmodule

// File: tb/tb_ifft_ovlp_discard.sv
// Bench for ifft_ovlp_discard: default-geometry instance plus a 64-point,
// zero-overlap, 2-bit frame counter instance, checked against a sample model.
module tb_ifft_ovlp_discard;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ch;
    logic [63:0] q;
    logic [11:0] bin;
    logic        sop;
    logic        eop;
    logic [15:0] frame;
    logic        err;
  } obs_t;

  typedef struct {
    int   pos;
    int   chan;
    int   frames;
    bit   err;
    obs_t o;
  } mdl_t;

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  ch;
    logic [63:0] d;
    obs_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_vi = 1'b0;
  logic [7:0]  a_chi = '0;
  logic [63:0] a_d = '0;
  logic        a_vo, a_sop, a_eop, a_err;
  logic [7:0]  a_cho;
  logic [63:0] a_q;
  logic [9:0]  a_bin;
  logic [15:0] a_fr;

  logic        b_rst = 1'b1, b_vi = 1'b0;
  logic [7:0]  b_chi = '0;
  logic [63:0] b_d = '0;
  logic        b_vo, b_sop, b_eop, b_err;
  logic [7:0]  b_cho;
  logic [63:0] b_q;
  logic [5:0]  b_bin;
  logic [1:0]  b_fr;

  ifft_ovlp_discard #(.FFT_LEN(1024), .OVERLAP(420), .FRAME_W(16)) u_a (
    .clk(clk), .rst(a_rst), .validIn(a_vi), .channelIn(a_chi), .d(a_d),
    .validOut(a_vo), .channelOut(a_cho), .q(a_q), .binOut(a_bin),
    .sopOut(a_sop), .eopOut(a_eop), .frameOut(a_fr), .errOut(a_err)
  );

  ifft_ovlp_discard #(.FFT_LEN(64), .OVERLAP(0), .FRAME_W(2)) u_b (
    .clk(clk), .rst(b_rst), .validIn(b_vi), .channelIn(b_chi), .d(b_d),
    .validOut(b_vo), .channelOut(b_cho), .q(b_q), .binOut(b_bin),
    .sopOut(b_sop), .eopOut(b_eop), .frameOut(b_fr), .errOut(b_err)
  );

  int checks = 0;
  int failures = 0;
  mdl_t ma, mb;
  int n_valid, n_sop, n_eop, last_eop_frame, sw_err;
  int eop_frames[$];

  function automatic obs_t mk(logic v, logic [7:0] ch, logic [63:0] qq, logic [11:0] bin,
                              logic sop, logic eop, logic [15:0] fr, logic err);
    obs_t o;
    o.valid = v; o.ch = ch; o.q = qq; o.bin = bin;
    o.sop = sop; o.eop = eop; o.frame = fr; o.err = err;
    return o;
  endfunction

  // Sample-level model: position within the frame decides drop/forward.
  function automatic void mstep(inout mdl_t m, input int len, input int ovl, input int fmod,
                                input bit r, input bit v, input logic [7:0] ch,
                                input logic [63:0] dd);
    if (r) begin
      m.pos = 0; m.chan = 0; m.frames = 0; m.err = 1'b0; m.o = '0;
      return;
    end
    m.o.valid = 1'b0; m.o.sop = 1'b0; m.o.eop = 1'b0;
    if (v) begin
      if (m.pos != 0 && int'(ch) != m.chan) begin
        m.err = 1'b1;
        m.pos = 0;
      end
      if (m.pos == 0) m.chan = int'(ch);
      if (m.pos >= ovl) begin
        m.o.valid = 1'b1;
        m.o.q     = dd;
        m.o.ch    = ch;
        m.o.bin   = 12'(m.pos - ovl);
        m.o.sop   = (m.pos == ovl);
        m.o.eop   = (m.pos == len - 1);
        m.o.frame = 16'(m.frames);
      end
      if (m.pos == len - 1) begin
        m.frames = (m.frames + 1) % fmod;
        m.pos = 0;
      end else begin
        m.pos++;
      end
    end
    m.o.err = m.err;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (v,ch,q,bin,sop,eop,frame,err)", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tally(input obs_t got);
    if (got.valid === 1'b1) n_valid++;
    if (got.sop === 1'b1) n_sop++;
    if (got.eop === 1'b1) begin
      n_eop++;
      last_eop_frame = int'(got.frame);
    end
  endtask

  task automatic cyc_a(input string name, input bit r, input bit v,
                       input logic [7:0] ch, input logic [63:0] dd);
    obs_t got;
    @(negedge clk);
    a_rst = r; a_vi = v; a_chi = ch; a_d = dd;
    mstep(ma, 1024, 420, 65536, r, v, ch, dd);
    @(posedge clk); #1;
    got = mk(a_vo, a_cho, a_q, 12'(a_bin), a_sop, a_eop, a_fr, a_err);
    chk(name, got, ma.o);
    tally(got);
    sw_err = int'(a_err);
  endtask

  task automatic cyc_b(input string name, input bit r, input bit v,
                       input logic [7:0] ch, input logic [63:0] dd, output obs_t got);
    @(negedge clk);
    b_rst = r; b_vi = v; b_chi = ch; b_d = dd;
    mstep(mb, 64, 0, 4, r, v, ch, dd);
    @(posedge clk); #1;
    got = mk(b_vo, b_cho, b_q, 12'(b_bin), b_sop, b_eop, 16'(b_fr), b_err);
    tally(got);
  endtask

  function automatic logic [63:0] pat(int i);
    logic [31:0] w;
    w = 32'(i);
    return {w, ~w};
  endfunction

  initial begin
    vec_t vec[9];
    obs_t got;
    int sent;
    int exp_fr[5] = '{0, 1, 2, 3, 0};

    vec[0] = '{1'b1, 1'b0, 8'd0, 64'h0,    mk(0, 0, 64'h0,    0, 0, 0, 0, 0)};
    vec[1] = '{1'b0, 1'b1, 8'd3, 64'hAAAA, mk(1, 3, 64'hAAAA, 0, 1, 0, 0, 0)};
    vec[2] = '{1'b0, 1'b0, 8'd3, 64'h1234, mk(0, 3, 64'hAAAA, 0, 0, 0, 0, 0)};
    vec[3] = '{1'b0, 1'b1, 8'd3, 64'hBBBB, mk(1, 3, 64'hBBBB, 1, 0, 0, 0, 0)};
    vec[4] = '{1'b0, 1'b1, 8'd4, 64'hCCCC, mk(1, 4, 64'hCCCC, 0, 1, 0, 0, 1)};
    vec[5] = '{1'b0, 1'b1, 8'd4, 64'hDDDD, mk(1, 4, 64'hDDDD, 1, 0, 0, 0, 1)};
    vec[6] = '{1'b1, 1'b0, 8'd4, 64'h0,    mk(0, 0, 64'h0,    0, 0, 0, 0, 0)};
    vec[7] = '{1'b0, 1'b1, 8'd9, 64'hEEEE, mk(1, 9, 64'hEEEE, 0, 1, 0, 0, 0)};
    vec[8] = '{1'b1, 1'b0, 8'd9, 64'h0,    mk(0, 0, 64'h0,    0, 0, 0, 0, 0)};

    // Default geometry: reset, then two back-to-back frames on channel 5.
    cyc_a("a_reset", 1'b1, 1'b0, 8'd0, 64'h0);
    cyc_a("a_reset", 1'b1, 1'b0, 8'd0, 64'h0);
    n_valid = 0; n_sop = 0; n_eop = 0; last_eop_frame = -1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 1024; i++) cyc_a("a_contig", 1'b0, 1'b1, 8'd5, pat(i));
    cyc_a("a_contig_tail", 1'b0, 1'b0, 8'd5, 64'h0);
    chk_int("a_contig_count", n_valid, 1208);
    chk_int("a_contig_sop", n_sop, 2);
    chk_int("a_contig_eop", n_eop, 2);
    chk_int("a_contig_last_frame", last_eop_frame, 1);

    // One frame with random valid gaps.
    n_valid = 0; n_sop = 0; n_eop = 0;
    sent = 0;
    while (sent < 1024) begin
      if ($urandom_range(0, 1) == 1) begin
        cyc_a("a_gaps", 1'b0, 1'b1, 8'd5, pat(sent));
        sent++;
      end else begin
        cyc_a("a_gaps", 1'b0, 1'b0, 8'd5, 64'(longint'($urandom())));
      end
    end
    cyc_a("a_gaps_tail", 1'b0, 1'b0, 8'd5, 64'h0);
    chk_int("a_gaps_count", n_valid, 604);
    chk_int("a_gaps_eop", n_eop, 1);

    // Channel switch 5 -> 6 at idx 700, then a full channel-6 frame.
    n_eop = 0; last_eop_frame = -1;
    for (int i = 0; i < 700; i++) cyc_a("a_chsw", 1'b0, 1'b1, 8'd5, pat(i));
    chk_int("a_chsw_err_before", sw_err, 0);
    cyc_a("a_chsw", 1'b0, 1'b1, 8'd6, pat(0));
    chk_int("a_chsw_err_after", sw_err, 1);
    for (int i = 1; i < 1024; i++) cyc_a("a_chsw", 1'b0, 1'b1, 8'd6, pat(i));
    cyc_a("a_chsw_tail", 1'b0, 1'b0, 8'd6, 64'h0);
    chk_int("a_chsw_eop", n_eop, 1);
    chk_int("a_chsw_frame", last_eop_frame, 3);

    // Reset mid-frame at idx 500, then a fresh frame.
    for (int i = 0; i < 500; i++) cyc_a("a_rstmid", 1'b0, 1'b1, 8'd7, pat(i));
    cyc_a("a_rstmid_rst", 1'b1, 1'b1, 8'd7, pat(500));
    n_eop = 0; last_eop_frame = -1;
    for (int i = 0; i < 1024; i++) cyc_a("a_rstmid_next", 1'b0, 1'b1, 8'd7, pat(i));
    cyc_a("a_rstmid_tail", 1'b0, 1'b0, 8'd7, 64'h0);
    chk_int("a_rstmid_frame", last_eop_frame, 0);
    chk_int("a_rstmid_err", sw_err, 0);

    // Random traffic with rare channel changes and resets.
    for (int i = 0; i < 1500; i++) begin
      automatic bit r = ($urandom_range(0, 999) < 3);
      automatic bit v = ($urandom_range(0, 9) < 7);
      automatic logic [7:0] ch = ($urandom_range(0, 99) < 1) ? 8'(i) : 8'd2;
      cyc_a("a_random", r, v, ch, {$urandom(), $urandom()});
    end
    @(negedge clk);
    a_vi = 1'b0;

    // Small instance: table vectors.
    for (int i = 0; i < 9; i++) begin
      cyc_b($sformatf("b_table_%0d", i), vec[i].r, vec[i].v, vec[i].ch, vec[i].d, got);
      chk($sformatf("b_table_%0d", i), got, vec[i].e);
    end

    // Five 64-sample frames with gaps: all forwarded, frame counter wraps at 4.
    n_valid = 0; n_sop = 0; n_eop = 0;
    eop_frames.delete();
    for (int f = 0; f < 5; f++) begin
      sent = 0;
      while (sent < 64) begin
        if ($urandom_range(0, 3) != 0) begin
          cyc_b("b_frames", 1'b0, 1'b1, 8'd1, pat(sent), got);
          sent++;
        end else begin
          cyc_b("b_frames", 1'b0, 1'b0, 8'd1, 64'h0, got);
        end
        chk("b_frames", got, mb.o);
        if (got.eop === 1'b1) eop_frames.push_back(int'(got.frame));
      end
    end
    cyc_b("b_frames_tail", 1'b0, 1'b0, 8'd1, 64'h0, got);
    chk("b_frames_tail", got, mb.o);
    chk_int("b_frames_count", n_valid, 320);
    chk_int("b_frames_sop", n_sop, 5);
    chk_int("b_frames_neop", eop_frames.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < eop_frames.size()) chk_int($sformatf("b_frame_seq_%0d", i), eop_frames[i], exp_fr[i]);

    // Small instance random traffic.
    for (int i = 0; i < 500; i++) begin
      automatic bit r = ($urandom_range(0, 199) < 1);
      automatic bit v = ($urandom_range(0, 9) < 8);
      automatic logic [7:0] ch = ($urandom_range(0, 49) < 1) ? 8'(i) : 8'd3;
      cyc_b("b_random", r, v, ch, {$urandom(), $urandom()}, got);
      chk("b_random", got, mb.o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifft_ovlp_discard.md
IFFT_OVLP_DISCARD -- requirements
Module: ifft_ovlp_discard

Interface
REQ-001 SHALL have parameter FFT_LEN, default 1024, meaning the IFFT frame length in samples (power of two, 64..4096).
REQ-002 SHALL have parameter OVERLAP, default 420, meaning the leading samples per frame discarded by overlap-save (0 <= OVERLAP < FFT_LEN).
REQ-003 SHALL have parameter FRAME_W, default 16, meaning the width of the frame counter.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 validIn  in  1  IFFT source valid; one sample per asserted cycle, gaps allowed.
REQ-007 channelIn  in  8  IFFT source channel (filter/template number).
REQ-008 d  in  64  IFFT output sample, [63:32] real, [31:0] imaginary, passed opaque.
REQ-009 validOut  out  1  retained-sample valid.
REQ-010 channelOut  out  8  channel of the retained sample.
REQ-011 q  out  64  retained sample, bit-identical to d.
REQ-012 binOut  out  clog2(FFT_LEN)  index within the retained region, 0..FFT_LEN-OVERLAP-1.
REQ-013 sopOut  out  1  first retained sample of a frame.
REQ-014 eopOut  out  1  last retained sample of a frame.
REQ-015 frameOut  out  FRAME_W  count of frames completed before this one for this output stream.
REQ-016 errOut  out  1  sticky channel-change-mid-frame error.

Function
REQ-017 SHALL keep sample counter idx (0..FFT_LEN-1), incremented only on validIn, wrapping FFT_LEN-1 -> 0.
REQ-018 SHALL latch channelIn on the sample with idx = 0 as the frame channel.
REQ-019 SHALL drop samples with idx < OVERLAP (no validOut).
REQ-020 SHALL forward samples with idx >= OVERLAP, with binOut = idx - OVERLAP, latency exactly 1 cycle (registered outputs).
REQ-021 SHALL assert sopOut with binOut = 0 and eopOut with binOut = FFT_LEN-OVERLAP-1; both only while validOut = 1.
REQ-022 SHALL increment frameOut after each sample at idx = FFT_LEN-1, wrapping modulo 2^FRAME_W.
REQ-023 SHALL, if validIn with idx != 0 and channelIn differs from the latched channel, set errOut, treat that sample as idx = 0 of a new frame (relatch channel, frameOut not incremented), and discard the partial frame without emitting eopOut.
REQ-024 SHALL hold q, channelOut, binOut at their last value and sopOut, eopOut at 0 when validOut = 0.
REQ-025 SHALL support back-to-back frames with no idle cycle; throughput one sample per clock.
REQ-026 SHALL keep a two-state FSM: DISCARD (idx < OVERLAP) and PASS (idx >= OVERLAP); DISCARD->PASS on the valid sample at idx = OVERLAP-1 (immediately PASS when OVERLAP = 0); PASS->DISCARD on idx = FFT_LEN-1 or REQ-023 restart.

Reset
REQ-027 SHALL on rst clear idx, frameOut, errOut, validOut, sopOut, eopOut, channelOut, binOut, q to 0 and enter DISCARD; errOut clears only by rst.
REQ-028 SHALL, on rst mid-frame, abandon that frame; the next validIn is idx = 0.

Structure
REQ-029 SHALL place FFT_LEN default, OVERLAP default, sample width 64 and the re/im field positions in shared package fdas_ifft_pkg.
REQ-030 SHALL be a single module; no sub-module needed.

Verification
REQ-031 Two contiguous frames, ch 5, d = {idx, ~idx} -> 604 outputs each, binOut 0..603, sop at d idx 420, eop at idx 1023, frameOut 0 then 1, latency 1 cycle.
REQ-032 Frame with validIn toggled 1/0 randomly -> same 604 outputs in order, no duplicates, no sop/eop when validOut = 0.
REQ-033 Channel switches 5 -> 6 at idx 700 -> errOut = 1 from next cycle, no eopOut for frame 5, following 1024 ch-6 samples give full frame with channelOut 6, frameOut unchanged.
REQ-034 rst pulsed at idx 500 -> outputs 0 next cycle; next frame starts at idx 0, frameOut 0, errOut 0.
REQ-035 OVERLAP = 0, FFT_LEN = 64 -> all 64 samples forwarded, sop at first, eop at 64th.
REQ-036 FRAME_W = 2, five frames -> frameOut sequence 0,1,2,3,0.
